// File: rtl/ex_mem_stage_pkg.sv
// Shared encodings for the EX stage: I-type ALUOp codes, R-type func codes
// and the internal ALU-control operation set.
package ex_mem_stage_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_SLT  = 3'b100;
  localparam logic [2:0] OP_SLTU = 3'b101;
  localparam logic [2:0] OP_LUI  = 3'b110;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_LUI, ALU_ZERO
  } alu_ctrl_e;

endpackage

// File: rtl/ex_alu.sv
// Combinational EX-stage ALU. The overflow flag is raised for any signed
// ADD/SUB wrap; whether it traps is decided by the caller.
import ex_mem_stage_pkg::*;

module ex_alu #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] cmp_b,
  input  alu_ctrl_e     ctrl,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          ovf
);

  logic [DW-1:0] sum;
  logic [DW-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;
  // Equality is taken against the register operand so beq ignores ALUSrc.
  assign zero = (a == cmp_b);

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (ctrl)
      ALU_ADD: begin
        result = sum;
        ovf    = (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1]);
      end
      ALU_SUB: begin
        result = diff;
        ovf    = (a[DW-1] != b[DW-1]) && (diff[DW-1] != a[DW-1]);
      end
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_NOR:  result = ~(a | b);
      ALU_SLT:  result = {{(DW-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: result = {{(DW-1){1'b0}}, (a < b)};
      ALU_LUI:  result = DW'({b[15:0], 16'h0000});
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX stage plus EX/MEM pipeline register: ALU-control decode, immediate
// extension, branch/jump resolution, all latched on the falling clock edge.
import ex_mem_stage_pkg::*;

module ex_mem_stage #(
  parameter int DW = 32,
  parameter int AW = 30
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [AW-1:0] B,
  input  logic [AW-1:0] Jtarg,
  input  logic [5:0]    func,
  input  logic [15:0]   imm16,
  input  logic [DW-1:0] busA,
  input  logic [DW-1:0] busB,
  input  logic [4:0]    Rt,
  input  logic [4:0]    Rd,
  input  logic          RegWr,
  input  logic          ALUSrc,
  input  logic          RegDst,
  input  logic          MemtoReg,
  input  logic          MemWr,
  input  logic          branch,
  input  logic          Jump,
  input  logic          ExtOp,
  input  logic          rtype,
  input  logic [2:0]    ALUOp,
  input  logic          stall,
  input  logic          flush,
  output logic          valid_out,
  output logic [DW-1:0] alu_out,
  output logic [DW-1:0] store_out,
  output logic [4:0]    Rw_out,
  output logic          RegWr_out,
  output logic          MemtoReg_out,
  output logic          MemWr_out,
  output logic          ovf_out,
  output logic          redirect_out,
  output logic [AW-1:0] target_out
);

  alu_ctrl_e     ctrl;
  logic          bad_func;
  logic          trap_en;
  logic [DW-1:0] ext_imm;
  logic [DW-1:0] op_b;
  logic [DW-1:0] alu_res;
  logic          alu_zero;
  logic          alu_ovf;
  logic          trap;
  logic          taken;
  logic [AW-1:0] target;

  always_comb begin
    ctrl     = ALU_ADD;
    bad_func = 1'b0;
    trap_en  = 1'b0;
    if (rtype) begin
      case (func)
        FN_ADD:  begin ctrl = ALU_ADD; trap_en = 1'b1; end
        FN_ADDU: ctrl = ALU_ADD;
        FN_SUB:  begin ctrl = ALU_SUB; trap_en = 1'b1; end
        FN_SUBU: ctrl = ALU_SUB;
        FN_AND:  ctrl = ALU_AND;
        FN_OR:   ctrl = ALU_OR;
        FN_XOR:  ctrl = ALU_XOR;
        FN_NOR:  ctrl = ALU_NOR;
        FN_SLT:  ctrl = ALU_SLT;
        FN_SLTU: ctrl = ALU_SLTU;
        default: begin ctrl = ALU_ZERO; bad_func = 1'b1; end
      endcase
    end else begin
      case (ALUOp)
        OP_ADD:  ctrl = ALU_ADD;
        OP_SUB:  ctrl = ALU_SUB;
        OP_OR:   ctrl = ALU_OR;
        OP_AND:  ctrl = ALU_AND;
        OP_SLT:  ctrl = ALU_SLT;
        OP_SLTU: ctrl = ALU_SLTU;
        OP_LUI:  ctrl = ALU_LUI;
        default: ctrl = ALU_ADD;
      endcase
    end
  end

  assign ext_imm = ExtOp ? {{(DW-16){imm16[15]}}, imm16} : {{(DW-16){1'b0}}, imm16};
  // LUI always takes its upper half from imm16, whatever ALUSrc says.
  assign op_b    = (ALUSrc || ctrl == ALU_LUI) ? ext_imm : busB;

  ex_alu #(.DW(DW)) u_alu (
    .a      (busA),
    .b      (op_b),
    .cmp_b  (busB),
    .ctrl   (ctrl),
    .result (alu_res),
    .zero   (alu_zero),
    .ovf    (alu_ovf)
  );

  assign trap   = trap_en & alu_ovf;
  assign taken  = Jump | (branch & alu_zero);
  assign target = Jump ? Jtarg : (B + {{(AW-16){imm16[15]}}, imm16});

  // Flush beats stall; an empty ID/EX slot loads the same bubble as a flush.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out    <= 1'b0;
      alu_out      <= '0;
      store_out    <= '0;
      Rw_out       <= '0;
      RegWr_out    <= 1'b0;
      MemtoReg_out <= 1'b0;
      MemWr_out    <= 1'b0;
      ovf_out      <= 1'b0;
      redirect_out <= 1'b0;
      target_out   <= '0;
    end else if (flush || (!stall && !in_valid)) begin
      valid_out    <= 1'b0;
      alu_out      <= '0;
      store_out    <= '0;
      Rw_out       <= '0;
      RegWr_out    <= 1'b0;
      MemtoReg_out <= 1'b0;
      MemWr_out    <= 1'b0;
      ovf_out      <= 1'b0;
      redirect_out <= 1'b0;
      target_out   <= '0;
    end else if (!stall) begin
      valid_out    <= 1'b1;
      alu_out      <= alu_res;
      store_out    <= busB;
      Rw_out       <= RegDst ? Rd : Rt;
      RegWr_out    <= RegWr & ~bad_func & ~trap;
      MemtoReg_out <= MemtoReg;
      MemWr_out    <= MemWr;
      ovf_out      <= trap;
      redirect_out <= taken;
      target_out   <= taken ? target : '0;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed, table-driven bench for ex_mem_stage with hand-computed expected
// values, plus stall/flush and asynchronous reset sequences.
module tb_ex_mem_stage;

  typedef struct packed {
    logic        in_valid;
    logic [29:0] B;
    logic [29:0] Jtarg;
    logic [5:0]  func;
    logic [15:0] imm16;
    logic [31:0] busA;
    logic [31:0] busB;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic        RegWr, ALUSrc, RegDst, MemtoReg, MemWr, branch, Jump, ExtOp, rtype;
    logic [2:0]  ALUOp;
  } in_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] alu;
    logic [31:0] store;
    logic [4:0]  rw;
    logic        regwr, memtoreg, memwr, ovf, redirect;
    logic [29:0] target;
  } exp_t;

  typedef struct {
    string name;
    in_t   i;
    exp_t  e;
  } vec_t;

  logic        clk, rst_n, in_valid, stall, flush;
  logic [29:0] B, Jtarg;
  logic [5:0]  func;
  logic [15:0] imm16;
  logic [31:0] busA, busB;
  logic [4:0]  Rt, Rd;
  logic        RegWr, ALUSrc, RegDst, MemtoReg, MemWr, branch, Jump, ExtOp, rtype;
  logic [2:0]  ALUOp;
  logic        valid_out, RegWr_out, MemtoReg_out, MemWr_out, ovf_out, redirect_out;
  logic [31:0] alu_out, store_out;
  logic [4:0]  Rw_out;
  logic [29:0] target_out;

  int errors = 0;
  int checks = 0;

  ex_mem_stage #(.DW(32), .AW(30)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .B(B), .Jtarg(Jtarg),
    .func(func), .imm16(imm16), .busA(busA), .busB(busB), .Rt(Rt), .Rd(Rd),
    .RegWr(RegWr), .ALUSrc(ALUSrc), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .MemWr(MemWr), .branch(branch), .Jump(Jump), .ExtOp(ExtOp), .rtype(rtype),
    .ALUOp(ALUOp), .stall(stall), .flush(flush), .valid_out(valid_out),
    .alu_out(alu_out), .store_out(store_out), .Rw_out(Rw_out),
    .RegWr_out(RegWr_out), .MemtoReg_out(MemtoReg_out), .MemWr_out(MemWr_out),
    .ovf_out(ovf_out), .redirect_out(redirect_out), .target_out(target_out)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic applyStimulus(input in_t s);
    in_valid = s.in_valid; B = s.B; Jtarg = s.Jtarg; func = s.func; imm16 = s.imm16;
    busA = s.busA; busB = s.busB; Rt = s.Rt; Rd = s.Rd; RegWr = s.RegWr;
    ALUSrc = s.ALUSrc; RegDst = s.RegDst; MemtoReg = s.MemtoReg; MemWr = s.MemWr;
    branch = s.branch; Jump = s.Jump; ExtOp = s.ExtOp; rtype = s.rtype; ALUOp = s.ALUOp;
  endtask

  task automatic checkField(input string tag, input string fld,
                            input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s.%s: got %h, expected %h", tag, fld, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input exp_t e);
    checkField(tag, "valid",    32'(valid_out),    32'(e.valid));
    checkField(tag, "alu",      alu_out,           e.alu);
    checkField(tag, "store",    store_out,         e.store);
    checkField(tag, "rw",       32'(Rw_out),       32'(e.rw));
    checkField(tag, "regwr",    32'(RegWr_out),    32'(e.regwr));
    checkField(tag, "memtoreg", 32'(MemtoReg_out), 32'(e.memtoreg));
    checkField(tag, "memwr",    32'(MemWr_out),    32'(e.memwr));
    checkField(tag, "ovf",      32'(ovf_out),      32'(e.ovf));
    checkField(tag, "redirect", 32'(redirect_out), 32'(e.redirect));
    checkField(tag, "target",   32'(target_out),   32'(e.target));
  endtask

  function automatic vec_t base(input string n);
    vec_t v;
    v.name = n;
    v.i = '0;
    v.i.in_valid = 1'b1;
    v.e = '0;
    v.e.valid = 1'b1;
    return v;
  endfunction

  function automatic vec_t rtypeVec(input string n, input logic [5:0] f,
                                    input logic [31:0] a, input logic [31:0] b);
    vec_t v;
    v = base(n);
    v.i.rtype = 1; v.i.func = f; v.i.busA = a; v.i.busB = b;
    v.i.Rd = 5'd3; v.i.Rt = 5'd17; v.i.RegDst = 1; v.i.RegWr = 1;
    v.e.store = b; v.e.rw = 5'd3; v.e.regwr = 1;
    return v;
  endfunction

  vec_t vecs[$];
  vec_t v;
  in_t  add_in;
  in_t  jump_in;
  exp_t add_exp;
  exp_t jump_exp;

  initial begin
    v = rtypeVec("add", 6'h20, 32'd7, 32'd5); v.e.alu = 32'd12; vecs.push_back(v);
    add_in = v.i; add_exp = v.e;
    v = rtypeVec("add_ovf", 6'h20, 32'h7FFFFFFF, 32'h1);
    v.e.alu = 32'h80000000; v.e.ovf = 1; v.e.regwr = 0; vecs.push_back(v);
    v = rtypeVec("addu", 6'h21, 32'h7FFFFFFF, 32'h1); v.e.alu = 32'h80000000; vecs.push_back(v);
    v = rtypeVec("sub", 6'h22, 32'd5, 32'd7); v.e.alu = 32'hFFFFFFFE; vecs.push_back(v);
    v = rtypeVec("sub_ovf", 6'h22, 32'h80000000, 32'h1);
    v.e.alu = 32'h7FFFFFFF; v.e.ovf = 1; v.e.regwr = 0; vecs.push_back(v);
    v = rtypeVec("subu", 6'h23, 32'h80000000, 32'h1); v.e.alu = 32'h7FFFFFFF; vecs.push_back(v);
    v = rtypeVec("nor", 6'h27, 32'h0F0F0F0F, 32'h00FF00FF); v.e.alu = 32'hF000F000; vecs.push_back(v);
    v = rtypeVec("xor", 6'h26, 32'h0F0F0F0F, 32'h00FF00FF); v.e.alu = 32'h0FF00FF0; vecs.push_back(v);
    v = rtypeVec("slt", 6'h2A, 32'hFFFFFFFF, 32'h1); v.e.alu = 32'h1; vecs.push_back(v);
    v = rtypeVec("sltu", 6'h2B, 32'hFFFFFFFF, 32'h1); v.e.alu = 32'h0; vecs.push_back(v);
    v = rtypeVec("bad_func", 6'h00, 32'd3, 32'd4); v.e.alu = 32'h0; v.e.regwr = 0; vecs.push_back(v);

    v = base("beq_taken");
    v.i.branch = 1; v.i.busA = 32'd9; v.i.busB = 32'd9; v.i.B = 30'h100; v.i.imm16 = 16'hFFFE;
    v.i.ExtOp = 1; v.i.ALUOp = 3'b001; v.i.Rt = 5'd2;
    v.e.alu = 32'h0; v.e.store = 32'd9; v.e.rw = 5'd2; v.e.redirect = 1; v.e.target = 30'h0FE;
    vecs.push_back(v);
    v.name = "beq_not"; v.i.busB = 32'd8;
    v.e.alu = 32'h1; v.e.store = 32'd8; v.e.redirect = 0; v.e.target = 30'h0;
    vecs.push_back(v);

    v = base("lw");
    v.i.ExtOp = 1; v.i.ALUSrc = 1; v.i.busA = 32'h1000; v.i.imm16 = 16'hFFFC; v.i.MemtoReg = 1;
    v.i.RegWr = 1; v.i.Rt = 5'd8; v.i.Rd = 5'd9; v.i.busB = 32'hDEAD;
    v.e.alu = 32'h0FFC; v.e.rw = 5'd8; v.e.regwr = 1; v.e.memtoreg = 1; v.e.store = 32'hDEAD;
    vecs.push_back(v);

    v = base("sw");
    v.i.MemWr = 1; v.i.ExtOp = 1; v.i.ALUSrc = 1; v.i.busA = 32'h2000; v.i.imm16 = 16'h0010;
    v.i.busB = 32'h55; v.i.Rt = 5'd4;
    v.e.alu = 32'h2010; v.e.store = 32'h55; v.e.memwr = 1; v.e.rw = 5'd4;
    vecs.push_back(v);

    v = base("ori_zext");
    v.i.ALUSrc = 1; v.i.busA = 32'h1234; v.i.imm16 = 16'h8000; v.i.ALUOp = 3'b010;
    v.i.RegWr = 1; v.i.Rt = 5'd5;
    v.e.alu = 32'h9234; v.e.rw = 5'd5; v.e.regwr = 1;
    vecs.push_back(v);

    v = base("lui");
    v.i.ALUSrc = 1; v.i.imm16 = 16'hABCD; v.i.ALUOp = 3'b110; v.i.RegWr = 1; v.i.Rt = 5'd6;
    v.i.busA = 32'h1111;
    v.e.alu = 32'hABCD0000; v.e.rw = 5'd6; v.e.regwr = 1;
    vecs.push_back(v);

    v = base("addi_no_trap");
    v.i.ExtOp = 1; v.i.ALUSrc = 1; v.i.busA = 32'h7FFFFFFF; v.i.imm16 = 16'h0001;
    v.i.RegWr = 1; v.i.Rt = 5'd7;
    v.e.alu = 32'h80000000; v.e.rw = 5'd7; v.e.regwr = 1;
    vecs.push_back(v);

    v = base("and_i");
    v.i.ALUOp = 3'b011; v.i.busA = 32'hFF00FF00; v.i.busB = 32'h0F0F0F0F;
    v.e.alu = 32'h0F000F00; v.e.store = 32'h0F0F0F0F;
    vecs.push_back(v);

    v = base("slt_i");
    v.i.ALUOp = 3'b100; v.i.ExtOp = 1; v.i.ALUSrc = 1; v.i.busA = 32'h1; v.i.imm16 = 16'hFFFF;
    v.e.alu = 32'h0;
    vecs.push_back(v);
    v.name = "sltu_i"; v.i.ALUOp = 3'b101; v.e.alu = 32'h1;
    vecs.push_back(v);

    v = base("reserved_add");
    v.i.ALUOp = 3'b111; v.i.ALUSrc = 1; v.i.busA = 32'd3; v.i.imm16 = 16'd4;
    v.e.alu = 32'd7;
    vecs.push_back(v);

    v = base("jump_wins");
    v.i.Jump = 1; v.i.branch = 1; v.i.busA = 32'd1; v.i.busB = 32'd2; v.i.Jtarg = 30'h2345678;
    v.i.B = 30'h100; v.i.imm16 = 16'h0010;
    v.e.alu = 32'd3; v.e.store = 32'd2; v.e.redirect = 1; v.e.target = 30'h2345678;
    vecs.push_back(v);
    jump_in = v.i; jump_exp = v.e;

    v = base("beq_wrap");
    v.i.branch = 1; v.i.B = 30'h0; v.i.imm16 = 16'hFFFF;
    v.e.redirect = 1; v.e.target = 30'h3FFFFFFF;
    vecs.push_back(v);

    v = base("not_valid");
    v.i.in_valid = 0; v.i.Jump = 1; v.i.Jtarg = 30'h55; v.i.RegWr = 1; v.i.busA = 32'd5;
    v.e = '0;
    vecs.push_back(v);

    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    applyStimulus('0);
    #12;
    checkOutput("reset", '0);
    @(posedge clk);
    rst_n = 1'b1;

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].i);
      @(negedge clk); #1;
      checkOutput(vecs[k].name, vecs[k].e);
    end

    // Stall holds a redirecting slot across three edges of changing inputs.
    applyStimulus(jump_in);
    @(negedge clk); #1;
    checkOutput("stall_load", jump_exp);
    stall = 1'b1;
    for (int n = 0; n < 3; n++) begin
      applyStimulus(add_in);
      busA = 32'(n * 100 + 1);
      @(negedge clk); #1;
      checkOutput($sformatf("stall_hold%0d", n), jump_exp);
    end
    flush = 1'b1;
    @(negedge clk); #1;
    checkOutput("stall_flush", '0);
    stall = 1'b0;

    applyStimulus(add_in);
    flush = 1'b0;
    @(negedge clk); #1;
    checkOutput("pre_flush", add_exp);
    flush = 1'b1;
    @(negedge clk); #1;
    checkOutput("flush", '0);
    flush = 1'b0;

    // Asynchronous reset between edges, then during a stall.
    @(negedge clk); #1;
    checkOutput("pre_reset", add_exp);
    #2 rst_n = 1'b0;
    #1 checkOutput("async_reset", '0);
    stall = 1'b1;
    @(negedge clk); #1;
    checkOutput("reset_held", '0);
    @(posedge clk);
    rst_n = 1'b1;
    stall = 1'b0;
    applyStimulus(add_in);
    @(negedge clk); #1;
    checkOutput("after_reset", add_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Consumer end of the ID/EX pipeline register. Takes the latched decode bundle (operands, immediate, register specifiers, ten control signals) and performs the EX stage: ALU control decode, immediate extension, ALU operation, branch/jump resolution.
- Latches the results into the EX/MEM register, with valid, stall and flush control.
- Sits between the ID/EX register and the data memory/write-back path. Drives the PC redirect back to fetch.

Parameters:
- DW, 32, datapath width (busA/busB/ALU result)
- AW, 30, word-address width of PC/branch/jump targets

Ports:
- clk  in  1  clock; all state updates on the falling edge, matching the other pipeline registers
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ID/EX slot holds a real instruction
- B  in  AW  PC+4 word address of the instruction
- Jtarg  in  AW  jump target word address
- func  in  6  R-type function field
- imm16  in  16  immediate
- busA, busB  in  DW  register operands
- Rt, Rd  in  5  register specifiers
- RegWr, ALUSrc, RegDst, MemtoReg, MemWr, branch, Jump, ExtOp, rtype  in  1 each  decoded controls
- ALUOp  in  3  ALU operation for non-R-type
- stall  in  1  hold the EX/MEM register
- flush  in  1  load a bubble into the EX/MEM register
- valid_out  out  1  EX/MEM slot valid
- alu_out  out  DW  ALU result / memory address
- store_out  out  DW  busB passed through as store data
- Rw_out  out  5  destination register
- RegWr_out, MemtoReg_out, MemWr_out  out  1 each  controls forwarded to MEM/WB
- ovf_out  out  1  signed overflow trapped
- redirect_out  out  1  taken branch or jump in this slot
- target_out  out  AW  redirect word address

Behaviour:
- Reset (rst_n=0, asynchronous, any time including mid-stall): every output register is 0. The first falling edge after release samples normally.
- Latency: one falling edge from the ID/EX bundle to the EX/MEM outputs. The EX computation is combinational within the half-cycle.
- Update priority per falling edge: flush > stall > load.
  - flush=1: load a bubble. valid_out, RegWr_out, MemWr_out, MemtoReg_out, redirect_out and ovf_out are all 0. Data fields are 0.
  - stall=1 (no flush): all outputs hold unchanged, including redirect_out.
  - in_valid=0 with no stall and no flush: load a bubble, identical to a flush.
- Immediate: ExtOp=1 sign-extends imm16 to DW bits; ExtOp=0 zero-extends it.
- Operand B: ALUSrc=1 selects the extended immediate; otherwise busB.
- Destination: Rw_out = RegDst ? Rd : Rt.
- ALU control, rtype=0, by ALUOp:
  - 000 ADD, 001 SUB, 010 OR, 011 AND
  - 100 SLT (signed), 101 SLTU
  - 110 LUI: result {imm16,16'b0}
  - 111 reserved: behaves as ADD
- ALU control, rtype=1, by func:
  - 100000 add, 100001 addu, 100010 sub, 100011 subu
  - 100100 and, 100101 or, 100110 xor, 100111 nor
  - 101010 slt, 101011 sltu
  - any other func: result 0, RegWr_out forced 0
- Overflow: signed overflow on add (100000) or sub (100010) sets ovf_out=1 and forces RegWr_out=0; alu_out still holds the wrapped sum. addu/subu and the I-type ADD/SUB never trap.
- Branch (beq): taken when branch=1 and busA==busB. target_out = B + sign-extended imm16, computed in AW bits with wrap-around (modulo 2^AW).
- Jump: Jump=1 gives taken, target_out = Jtarg. If both branch and Jump are set, Jump wins.
- Redirect: redirect_out=1 only when the slot is valid and taken; otherwise target_out=0. Fetch consumes the redirect on the first non-stalled edge. This block never flushes its own input; the hazard logic flushes younger stages.
- SLT/SLTU results are 32'h1 or 32'h0.
- store_out = busB regardless of ALUSrc.

Decomposition:
- Shared package: ALUOp codes, func codes, ALU-control enum.
- One combinational sub-module, ex_alu (operands plus ALU-control in; result, zero and overflow out). The EX/MEM register, extension and branch logic stay in ex_mem_stage.

Test Plan:
- R-type add, busA=7, busB=5, Rd=3, RegDst=1 -> one edge later alu_out=12, Rw_out=3, RegWr_out=1, valid_out=1.
- add 7FFFFFFF+1 -> alu_out=80000000, ovf_out=1, RegWr_out=0; same operands with addu -> ovf_out=0, RegWr_out=1.
- beq, busA=busB=9, B=0x100, imm16=FFFE -> redirect_out=1, target_out=0x0FE; busB=8 -> redirect_out=0, target_out=0.
- lw, ExtOp=1, ALUSrc=1, busA=0x1000, imm16=FFFC, MemtoReg=1 -> alu_out=0x0FFC, Rw_out=Rt.
- Valid instruction loaded, then stall=1 for 3 edges with changing inputs -> outputs frozen; stall=flush=1 together -> bubble (valid_out=0, redirect_out=0).
- Drop rst_n between edges while valid_out=1 -> all outputs 0 immediately without a clock edge; release, then one valid instruction -> normal result.
